// File: rtl/kex_tile_loader_if.sv
// Sparse kernel element stream: {weight, channel index} with valid/ready handshake.
interface kex_tile_loader_if #(
   parameter int WG_W = 8,
   parameter int IW   = 3
);
   logic            s_valid;
   logic [WG_W-1:0] s_weight;
   logic [IW-1:0]   s_idx;
   logic            s_ready;

   modport master (output s_valid, s_weight, s_idx, input s_ready);
   modport slave  (input s_valid, s_weight, s_idx, output s_ready);
endinterface

// File: rtl/kex_tile_loader.sv
// Tile RAM fill stage: packs stream elements into consecutive RAM words from address 0.
// Write path is registered (1-cycle latency); stream is back-pressured whenever not loading.
module kex_tile_loader #(
   parameter int KEX_N_ELEM = 64,
   parameter int WG_W       = 8,
   parameter int Npar       = 8,
   localparam int AW        = $clog2(KEX_N_ELEM),
   localparam int IW        = $clog2(Npar)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic [AW:0]          n_elem,
   kex_tile_loader_if.slave     s,
   input  logic [AW-1:0]        rd_addr,
   output logic [AW-1:0]        ram_addr,
   output logic [WG_W+IW-1:0]   ram_data,
   output logic                 ram_write,
   output logic                 busy,
   output logic                 done
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] LOAD = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   localparam logic [AW:0] N_MAX = (AW+1)'(KEX_N_ELEM);
   localparam logic [AW:0] ONE   = (AW+1)'(1);

   logic [1:0]  state;
   logic [AW:0] count;
   logic [AW:0] n_eff;
   logic [AW:0] n_clip;
   logic        transfer;

   // Requests beyond the RAM depth are clipped so the address never wraps.
   assign n_clip   = (n_elem > N_MAX) ? N_MAX : n_elem;
   assign s.s_ready = (state == LOAD);
   assign transfer = s.s_valid & s.s_ready;
   assign busy     = (state == LOAD);
   assign done     = (state == DONE);

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         count     <= '0;
         n_eff     <= '0;
         ram_write <= 1'b0;
         ram_data  <= '0;
         ram_addr  <= '0;
      end else begin
         ram_write <= transfer;
         // The consumer owns the address port on every cycle without a write.
         if (transfer) begin
            ram_addr <= count[AW-1:0];
            ram_data <= {s.s_weight, s.s_idx};
            count    <= count + ONE;
         end else begin
            ram_addr <= rd_addr;
         end

         case (state)
            IDLE: begin
               if (start) begin
                  count <= '0;
                  n_eff <= n_clip;
                  state <= (n_clip == '0) ? DONE : LOAD;
               end
            end
            LOAD: begin
               if (transfer && (count == n_eff - ONE)) begin
                  state <= DONE;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_kex_tile_loader.sv
// Scoreboard bench for kex_tile_loader: expected RAM writes are queued at issue, checked by a monitor.
module tb_kex_tile_loader;

   localparam int N    = 64;
   localparam int WG_W = 8;
   localparam int NPAR = 8;
   localparam int AW   = 6;
   localparam int IW   = 3;

   typedef struct packed {
      logic [AW-1:0]      addr;
      logic [WG_W+IW-1:0] data;
      logic               last;
   } exp_t;

   logic                 clk = 1'b0;
   logic                 reset;
   logic                 start;
   logic [AW:0]          n_elem;
   logic [AW-1:0]        rd_addr;
   logic [AW-1:0]        ram_addr;
   logic [WG_W+IW-1:0]   ram_data;
   logic                 ram_write;
   logic                 busy;
   logic                 done;

   kex_tile_loader_if #(.WG_W(WG_W), .IW(IW)) s_if ();

   kex_tile_loader #(.KEX_N_ELEM(N), .WG_W(WG_W), .Npar(NPAR)) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .n_elem   (n_elem),
      .s        (s_if),
      .rd_addr  (rd_addr),
      .ram_addr (ram_addr),
      .ram_data (ram_data),
      .ram_write(ram_write),
      .busy     (busy),
      .done     (done)
   );

   always #5 clk = ~clk;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_pass   = 0;
   int   done_cnt = 0;
   int   wr_cnt   = 0;
   bit   sready_seen = 1'b0;
   int   exp_addr;
   int   n_eff;

   task automatic check(input string name, input longint act, input longint req);
      n_checks++;
      if (act == req) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, req);
   endtask

   // Monitor: every RAM write must match the head of the scoreboard.
   always @(negedge clk) begin
      exp_t e;
      if (done) done_cnt++;
      if (s_if.s_ready) sready_seen = 1'b1;
      if (ram_write) begin
         wr_cnt++;
         if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_write: addr %0d data %0h, expected no write", ram_addr, ram_data);
         end else begin
            e = exp_q.pop_front();
            check("wr_addr", ram_addr, e.addr);
            check("wr_data", ram_data, e.data);
            check("wr_done_coincident", done, e.last);
         end
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_start(input int n);
      start  = 1'b1;
      n_elem = (AW+1)'(n);
      tick();
      start  = 1'b0;
      exp_addr = 0;
      n_eff = (n > N) ? N : n;
   endtask

   task automatic send(input logic [WG_W-1:0] w, input logic [IW-1:0] idx);
      exp_t e;
      s_if.s_valid  = 1'b1;
      s_if.s_weight = w;
      s_if.s_idx    = idx;
      e.addr = AW'(exp_addr);
      e.data = {w, idx};
      e.last = (exp_addr == n_eff - 1);
      exp_q.push_back(e);
      exp_addr++;
      tick();
      s_if.s_valid = 1'b0;
   endtask

   task automatic gap;
      s_if.s_valid = 1'b0;
      tick();
   endtask

   task automatic settle_and_check(input string name, input int d0, input int w0,
                                   input int d_req, input int w_req);
      repeat (3) tick();
      check({name, "_queue_drained"}, exp_q.size(), 0);
      check({name, "_done_pulses"}, done_cnt - d0, d_req);
      check({name, "_writes"}, wr_cnt - w0, w_req);
      check({name, "_busy_idle"}, busy, 0);
   endtask

   initial begin
      int d0;
      int w0;
      reset = 1'b1;
      start = 1'b0;
      n_elem = '0;
      rd_addr = '0;
      s_if.s_valid = 1'b0;
      s_if.s_weight = '0;
      s_if.s_idx = '0;
      repeat (3) tick();
      check("rst_ram_write", ram_write, 0);
      check("rst_ram_addr", ram_addr, 0);
      check("rst_ram_data", ram_data, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_s_ready", s_if.s_ready, 0);
      reset = 1'b0;
      tick();

      // Back-to-back 4 elements
      d0 = done_cnt; w0 = wr_cnt;
      do_start(4);
      check("t1_busy", busy, 1);
      send(8'h11, 3'd0);
      send(8'h22, 3'd1);
      send(8'h33, 3'd2);
      send(8'h44, 3'd3);
      settle_and_check("t1", d0, w0, 1, 4);

      // Gapped stream 1,0,0,1,0,1
      d0 = done_cnt; w0 = wr_cnt;
      do_start(3);
      send(8'hA1, 3'd5);
      gap(); gap();
      send(8'hB2, 3'd6);
      gap();
      send(8'hC3, 3'd7);
      settle_and_check("t2", d0, w0, 1, 3);

      // Zero-length tile
      d0 = done_cnt; w0 = wr_cnt;
      sready_seen = 1'b0;
      do_start(0);
      @(negedge clk);
      check("t3_done_after_start", done, 1);
      tick();
      check("t3_done_one_cycle", done, 0);
      settle_and_check("t3", d0, w0, 1, 0);
      check("t3_s_ready_never", sready_seen, 0);

      // Oversized request clipped to RAM depth; extra valids must not be accepted
      d0 = done_cnt; w0 = wr_cnt;
      do_start(N + 5);
      for (int i = 0; i < N; i++) send(WG_W'(i + 1), IW'(i));
      s_if.s_valid = 1'b1;
      repeat (5) tick();
      s_if.s_valid = 1'b0;
      settle_and_check("t4", d0, w0, 1, N);

      // Read-address forwarding in IDLE
      rd_addr = 6'd5;
      tick();
      check("t5_rd_fwd_addr", ram_addr, 5);
      check("t5_rd_fwd_nowrite", ram_write, 0);
      rd_addr = 6'd42;
      tick();
      check("t5_rd_fwd_addr2", ram_addr, 42);
      rd_addr = '0;

      // Start pulse during LOAD is ignored
      d0 = done_cnt; w0 = wr_cnt;
      do_start(3);
      send(8'h5A, 3'd1);
      start = 1'b1;
      n_elem = '0;
      send(8'h6B, 3'd2);
      start = 1'b0;
      send(8'h7C, 3'd3);
      settle_and_check("t6", d0, w0, 1, 3);

      // Reset after 2 of 6 transfers drops the pending write
      d0 = done_cnt; w0 = wr_cnt;
      do_start(6);
      send(8'hD1, 3'd0);
      send(8'hD2, 3'd1);
      reset = 1'b1;
      s_if.s_valid = 1'b1;
      s_if.s_weight = 8'hD3;
      s_if.s_idx = 3'd2;
      tick();
      reset = 1'b0;
      s_if.s_valid = 1'b0;
      check("t7_rst_write_dropped", ram_write, 0);
      check("t7_rst_busy", busy, 0);
      check("t7_rst_s_ready", s_if.s_ready, 0);
      tick();
      do_start(2);
      send(8'hE1, 3'd4);
      send(8'hE2, 3'd5);
      settle_and_check("t7", d0, w0, 1, 4);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
